// File: rtl/insn_sequencer_pkg.sv
// Shared opcode, state and unit-select definitions for the instruction sequencer.
// Also used by the emulator display through insn_decoder.
package insn_sequencer_pkg;

  localparam int INSN_WIDTH = 4;

  localparam logic [INSN_WIDTH-1:0] INSN_NOP        = 4'h0;
  localparam logic [INSN_WIDTH-1:0] INSN_INC        = 4'h1;
  localparam logic [INSN_WIDTH-1:0] INSN_DEC        = 4'h2;
  localparam logic [INSN_WIDTH-1:0] INSN_RIGHT      = 4'h3;
  localparam logic [INSN_WIDTH-1:0] INSN_LEFT       = 4'h4;
  localparam logic [INSN_WIDTH-1:0] INSN_LOOP_OPEN  = 4'h5;
  localparam logic [INSN_WIDTH-1:0] INSN_LOOP_CLOSE = 4'h6;
  localparam logic [INSN_WIDTH-1:0] INSN_OUT        = 4'h7;
  localparam logic [INSN_WIDTH-1:0] INSN_IN         = 4'h8;
  localparam logic [INSN_WIDTH-1:0] INSN_HALT       = 4'hF;

  typedef enum logic [5:0] {
    SEQ_IDLE      = 6'b000001,
    SEQ_PREP      = 6'b000010,
    SEQ_FETCH     = 6'b000100,
    SEQ_DECODE    = 6'b001000,
    SEQ_EXEC_WAIT = 6'b010000,
    SEQ_HALTED    = 6'b100000
  } seq_state_e;

  localparam logic [2:0] UNIT_NONE = 3'd0;
  localparam logic [2:0] UNIT_DATA = 3'd1;
  localparam logic [2:0] UNIT_AP   = 3'd2;
  localparam logic [2:0] UNIT_OUT  = 3'd3;
  localparam logic [2:0] UNIT_IN   = 3'd4;
  localparam logic [2:0] UNIT_HALT = 3'd5;

endpackage

// File: rtl/insn_sequencer_decoder.sv
// Combinational opcode decode: which execution unit an instruction targets and
// its direction bit. Loop opcodes and unknown codes need no unit.
module insn_decoder
  import insn_sequencer_pkg::*;
(
  input  logic [INSN_WIDTH-1:0] insn,
  output logic [2:0]            unit,
  output logic                  dir_dec
);

  always_comb begin
    unit    = UNIT_NONE;
    dir_dec = 1'b0;
    case (insn)
      INSN_INC:   unit = UNIT_DATA;
      INSN_DEC: begin
        unit    = UNIT_DATA;
        dir_dec = 1'b1;
      end
      INSN_RIGHT: unit = UNIT_AP;
      INSN_LEFT: begin
        unit    = UNIT_AP;
        dir_dec = 1'b1;
      end
      INSN_OUT:   unit = UNIT_OUT;
      INSN_IN:    unit = UNIT_IN;
      INSN_HALT:  unit = UNIT_HALT;
      INSN_NOP, INSN_LOOP_OPEN, INSN_LOOP_CLOSE: unit = UNIT_NONE;
      default:    unit = UNIT_NONE;
    endcase
  end

endmodule

// File: rtl/insn_sequencer.sv
// Execution control stage: fetches from the IP line, dispatches each
// instruction to the data/AP counters or console, and counts retirements.
//
// state     | meaning
// IDLE      | waiting for Run or Step
// PREP      | snapshot Data_Zero into DataIsZeroed
// FETCH     | Ip_Request issued, waiting for Ip_Ready
// DECODE    | dispatch registered instruction to its unit
// EXEC_WAIT | waiting for the unit's Ready/Ack
// HALTED    | terminal until reset
module insn_sequencer
  import insn_sequencer_pkg::*;
#(
  parameter int RETIRE_WIDTH = 16
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    Run,
  input  logic                    Step,
  output logic                    Ip_Request,
  input  logic                    Ip_Ready,
  input  logic [INSN_WIDTH-1:0]   Insn,
  output logic                    DataIsZeroed,
  output logic                    Ap_Request,
  output logic                    Ap_Dec,
  input  logic                    Ap_Ready,
  output logic                    Data_Request,
  output logic                    Data_Dec,
  input  logic                    Data_Ready,
  input  logic                    Data_Zero,
  output logic                    Out_Strobe,
  input  logic                    Out_Ack,
  output logic                    In_Request,
  input  logic                    In_Ready,
  output logic                    Busy,
  output logic                    Halted,
  output logic [RETIRE_WIDTH-1:0] Retired
);

  seq_state_e              state_q, state_d;
  logic [INSN_WIDTH-1:0]   insn_q, insn_d;
  logic [2:0]              unit_q, unit_d;
  logic                    step_q, step_d;
  logic                    guard_q, guard_d;
  logic                    ip_req_q, ip_req_d;
  logic                    ap_req_q, ap_req_d;
  logic                    ap_dec_q, ap_dec_d;
  logic                    data_req_q, data_req_d;
  logic                    data_dec_q, data_dec_d;
  logic                    out_q, out_d;
  logic                    in_q, in_d;
  logic                    diz_q, diz_d;
  logic                    halted_q, halted_d;
  logic [RETIRE_WIDTH-1:0] retired_q, retired_d;

  logic [2:0] dec_unit;
  logic       dec_dir;
  logic       ready_ok;
  logic       retire;

  insn_decoder u_decoder (
    .insn    (insn_q),
    .unit    (dec_unit),
    .dir_dec (dec_dir)
  );

  // Ready is blind in the request cycle and the one after: the unit's idle
  // flag only drops a cycle after it sees the pulse.
  assign ready_ok = !(ip_req_q || ap_req_q || data_req_q || guard_q);

  always_comb begin
    state_d    = state_q;
    insn_d     = insn_q;
    unit_d     = unit_q;
    step_d     = step_q;
    guard_d    = ip_req_q || ap_req_q || data_req_q;
    ip_req_d   = 1'b0;
    ap_req_d   = 1'b0;
    ap_dec_d   = ap_dec_q;
    data_req_d = 1'b0;
    data_dec_d = data_dec_q;
    out_d      = out_q;
    in_d       = in_q;
    diz_d      = diz_q;
    halted_d   = halted_q;
    retired_d  = retired_q;
    retire     = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        if (Run || Step) begin
          state_d = SEQ_PREP;
          step_d  = !Run;
        end
      end
      SEQ_PREP: begin
        diz_d    = Data_Zero;
        ip_req_d = 1'b1;
        state_d  = SEQ_FETCH;
      end
      SEQ_FETCH: begin
        if (ready_ok && Ip_Ready) begin
          insn_d  = Insn;
          state_d = SEQ_DECODE;
        end
      end
      SEQ_DECODE: begin
        unit_d = dec_unit;
        case (dec_unit)
          UNIT_DATA: begin
            data_req_d = 1'b1;
            data_dec_d = dec_dir;
            state_d    = SEQ_EXEC_WAIT;
          end
          UNIT_AP: begin
            ap_req_d = 1'b1;
            ap_dec_d = dec_dir;
            state_d  = SEQ_EXEC_WAIT;
          end
          UNIT_OUT: begin
            out_d   = 1'b1;
            state_d = SEQ_EXEC_WAIT;
          end
          UNIT_IN: begin
            in_d    = 1'b1;
            state_d = SEQ_EXEC_WAIT;
          end
          UNIT_HALT: begin
            halted_d = 1'b1;
            state_d  = SEQ_HALTED;
          end
          default: retire = 1'b1;
        endcase
      end
      SEQ_EXEC_WAIT: begin
        case (unit_q)
          UNIT_DATA: retire = ready_ok && Data_Ready;
          UNIT_AP:   retire = ready_ok && Ap_Ready;
          UNIT_OUT: begin
            if (Out_Ack) begin
              out_d  = 1'b0;
              retire = 1'b1;
            end
          end
          UNIT_IN: begin
            if (In_Ready) begin
              in_d   = 1'b0;
              retire = 1'b1;
            end
          end
          default: retire = 1'b1;
        endcase
      end
      SEQ_HALTED: state_d = SEQ_HALTED;
      default:    state_d = SEQ_IDLE;
    endcase

    if (retire) begin
      retired_d = retired_q + RETIRE_WIDTH'(1);
      if (Run && !step_q) begin
        state_d = SEQ_PREP;
      end else begin
        state_d = SEQ_IDLE;
        step_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= SEQ_IDLE;
      insn_q     <= INSN_NOP;
      unit_q     <= UNIT_NONE;
      step_q     <= 1'b0;
      guard_q    <= 1'b0;
      ip_req_q   <= 1'b0;
      ap_req_q   <= 1'b0;
      ap_dec_q   <= 1'b0;
      data_req_q <= 1'b0;
      data_dec_q <= 1'b0;
      out_q      <= 1'b0;
      in_q       <= 1'b0;
      diz_q      <= 1'b1;
      halted_q   <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      insn_q     <= insn_d;
      unit_q     <= unit_d;
      step_q     <= step_d;
      guard_q    <= guard_d;
      ip_req_q   <= ip_req_d;
      ap_req_q   <= ap_req_d;
      ap_dec_q   <= ap_dec_d;
      data_req_q <= data_req_d;
      data_dec_q <= data_dec_d;
      out_q      <= out_d;
      in_q       <= in_d;
      diz_q      <= diz_d;
      halted_q   <= halted_d;
      retired_q  <= retired_d;
    end
  end

  assign Ip_Request   = ip_req_q;
  assign Ap_Request   = ap_req_q;
  assign Ap_Dec       = ap_dec_q;
  assign Data_Request = data_req_q;
  assign Data_Dec     = data_dec_q;
  assign Out_Strobe   = out_q;
  assign In_Request   = in_q;
  assign DataIsZeroed = diz_q;
  assign Halted       = halted_q;
  assign Retired      = retired_q;
  assign Busy         = (state_q != SEQ_IDLE) && (state_q != SEQ_HALTED);

endmodule

// File: tb/tb_insn_sequencer.sv
// Directed bench for insn_sequencer: behavioural IP line, counters and console,
// with a scoreboard of expected unit dispatches checked by a separate monitor.
module tb_insn_sequencer;
  import insn_sequencer_pkg::*;

  localparam logic [7:0] EV_D_INC = 8'h10, EV_D_DEC = 8'h11;
  localparam logic [7:0] EV_A_R   = 8'h20, EV_A_L   = 8'h21;
  localparam logic [7:0] EV_OUT   = 8'h30, EV_IN    = 8'h40;

  logic        Clk = 1'b0;
  logic        Rst_n, Run, Step;
  logic        Ip_Request, Ip_Ready;
  logic [3:0]  Insn;
  logic        DataIsZeroed;
  logic        Ap_Request, Ap_Dec, Ap_Ready;
  logic        Data_Request, Data_Dec, Data_Ready, Data_Zero;
  logic        Out_Strobe, Out_Ack, In_Request, In_Ready;
  logic        Busy, Halted;
  logic [15:0] Retired;

  int n_tests = 0;
  int n_fail  = 0;
  int ip_cnt  = 0;
  int ip_delay = 2, data_delay = 3, ap_delay = 2, out_delay = 10, in_delay = 2;
  logic [3:0] prog[$];
  int         pc = 0;
  logic [7:0] exp_q[$];

  always #5 Clk = ~Clk;

  insn_sequencer #(.RETIRE_WIDTH(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Step(Step),
    .Ip_Request(Ip_Request), .Ip_Ready(Ip_Ready), .Insn(Insn),
    .DataIsZeroed(DataIsZeroed),
    .Ap_Request(Ap_Request), .Ap_Dec(Ap_Dec), .Ap_Ready(Ap_Ready),
    .Data_Request(Data_Request), .Data_Dec(Data_Dec), .Data_Ready(Data_Ready),
    .Data_Zero(Data_Zero),
    .Out_Strobe(Out_Strobe), .Out_Ack(Out_Ack),
    .In_Request(In_Request), .In_Ready(In_Ready),
    .Busy(Busy), .Halted(Halted), .Retired(Retired)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // IP line: idle flag drops a cycle after the request, returns with the next opcode
  initial begin
    Ip_Ready = 1'b1;
    Insn     = INSN_NOP;
    forever begin
      @(negedge Clk);
      if (Ip_Request) begin
        @(negedge Clk);
        Ip_Ready = 1'b0;
        repeat (ip_delay) @(negedge Clk);
        Insn = (pc < prog.size()) ? prog[pc] : INSN_HALT;
        pc++;
        Ip_Ready = 1'b1;
      end
    end
  end

  initial begin
    Data_Ready = 1'b1;
    forever begin
      @(negedge Clk);
      if (Data_Request) begin
        @(negedge Clk);
        Data_Ready = 1'b0;
        repeat (data_delay) @(negedge Clk);
        Data_Ready = 1'b1;
      end
    end
  end

  initial begin
    Ap_Ready = 1'b1;
    forever begin
      @(negedge Clk);
      if (Ap_Request) begin
        @(negedge Clk);
        Ap_Ready = 1'b0;
        repeat (ap_delay) @(negedge Clk);
        Ap_Ready = 1'b1;
      end
    end
  end

  initial begin
    Out_Ack = 1'b0;
    forever begin
      @(negedge Clk);
      if (Out_Strobe) begin
        repeat (out_delay) @(negedge Clk);
        Out_Ack = 1'b1;
        @(negedge Clk);
        Out_Ack = 1'b0;
      end
    end
  end

  initial begin
    In_Ready = 1'b0;
    forever begin
      @(negedge Clk);
      if (In_Request) begin
        repeat (in_delay) @(negedge Clk);
        In_Ready = 1'b1;
        @(negedge Clk);
        In_Ready = 1'b0;
      end
    end
  end

  // Monitor: every dispatch the DUT presents must match the head of the scoreboard
  initial begin
    logic       prev_out, prev_in, ev_valid;
    logic [7:0] ev;
    prev_out = 1'b0;
    prev_in  = 1'b0;
    forever begin
      @(negedge Clk);
      if (Ip_Request === 1'b1) ip_cnt++;
      ev_valid = 1'b0;
      ev       = 8'h00;
      if (Data_Request === 1'b1) begin
        ev = {7'h08, Data_Dec}; ev_valid = 1'b1;
      end else if (Ap_Request === 1'b1) begin
        ev = {7'h10, Ap_Dec};   ev_valid = 1'b1;
      end else if (Out_Strobe === 1'b1 && !prev_out) begin
        ev = EV_OUT;            ev_valid = 1'b1;
      end else if (In_Request === 1'b1 && !prev_in) begin
        ev = EV_IN;             ev_valid = 1'b1;
      end
      if (ev_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got %0h, required no event", ev);
        end else begin
          check("sb_event", 32'(ev), 32'(exp_q.pop_front()));
        end
      end
      prev_out = (Out_Strobe === 1'b1);
      prev_in  = (In_Request === 1'b1);
    end
  end

  task automatic apply_reset();
    Rst_n = 1'b0;
    Run   = 1'b0;
    Step  = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic wait_halted(input string name);
    for (int i = 0; i < 300 && Halted !== 1'b1; i++) @(negedge Clk);
    check(name, 32'(Halted), 32'd1);
  endtask

  task automatic wait_fetch(input string name);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge Clk);
      seen = (Ip_Request === 1'b1);
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    int ip_start, cnt;
    bit busy_all, seen;
    Rst_n = 1'b0; Run = 1'b1; Step = 1'b0; Data_Zero = 1'b0;

    // reset held with Run high
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      check("rst_no_req", 32'({Ip_Request, Ap_Request, Data_Request}), 32'd0);
    end
    check("rst_strobes", 32'({Out_Strobe, In_Request}), 32'd0);
    check("rst_dirs", 32'({Ap_Dec, Data_Dec}), 32'd0);
    check("rst_diz", 32'(DataIsZeroed), 32'd1);
    check("rst_halted", 32'(Halted), 32'd0);
    check("rst_retired", 32'(Retired), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    Run = 1'b0;
    Rst_n = 1'b1;
    @(negedge Clk);

    // + + - HALT
    prog = {INSN_INC, INSN_INC, INSN_DEC, INSN_HALT}; pc = 0;
    data_delay = 3;
    exp_q.push_back(EV_D_INC); exp_q.push_back(EV_D_INC); exp_q.push_back(EV_D_DEC);
    Run = 1'b1;
    wait_halted("prog1_halt");
    check("prog1_retired", 32'(Retired), 32'd3);
    check("prog1_busy", 32'(Busy), 32'd0);
    check("prog1_sb_empty", 32'(exp_q.size()), 32'd0);
    ip_start = ip_cnt;
    Step = 1'b1; @(negedge Clk); Step = 1'b0;
    repeat (10) @(negedge Clk);
    check("halted_no_fetch", 32'(ip_cnt - ip_start), 32'd0);
    check("halted_sticky", 32'(Halted), 32'd1);

    // loop opcode and unknown code, current cell nonzero
    apply_reset();
    Data_Zero = 1'b0;
    prog = {INSN_LOOP_OPEN, 4'h9, INSN_HALT}; pc = 0;
    Run = 1'b1;
    wait_fetch("loop_fetch1");
    check("loop_diz0_f1", 32'(DataIsZeroed), 32'd0);
    wait_fetch("loop_fetch2");
    check("loop_diz0_f2", 32'(DataIsZeroed), 32'd0);
    check("loop_retired_f2", 32'(Retired), 32'd1);
    wait_halted("loop0_halt");
    check("loop0_retired", 32'(Retired), 32'd2);

    // loop opcode, current cell zero
    apply_reset();
    Data_Zero = 1'b1;
    prog = {INSN_LOOP_OPEN, INSN_HALT}; pc = 0;
    Run = 1'b1;
    wait_fetch("loopz_fetch1");
    wait_fetch("loopz_fetch2");
    check("loopz_diz1", 32'(DataIsZeroed), 32'd1);
    check("loopz_retired", 32'(Retired), 32'd1);
    wait_halted("loopz_halt");
    check("loopz_sb_empty", 32'(exp_q.size()), 32'd0);

    // single step of '>'
    apply_reset();
    Data_Zero = 1'b0;
    prog = {INSN_RIGHT, INSN_RIGHT}; pc = 0;
    exp_q.push_back(EV_A_R);
    ip_start = ip_cnt;
    Step = 1'b1; @(negedge Clk); Step = 1'b0;
    repeat (30) @(negedge Clk);
    check("step_one_fetch", 32'(ip_cnt - ip_start), 32'd1);
    check("step_retired", 32'(Retired), 32'd1);
    check("step_idle", 32'(Busy), 32'd0);
    check("step_sb_empty", 32'(exp_q.size()), 32'd0);

    // Run+Step together runs; '.' with slow ack, then ',' and '<'
    prog = {INSN_OUT, INSN_IN, INSN_LEFT, INSN_HALT}; pc = 0;
    out_delay = 10; in_delay = 2;
    exp_q.push_back(EV_OUT); exp_q.push_back(EV_IN); exp_q.push_back(EV_A_L);
    Run = 1'b1; Step = 1'b1; @(negedge Clk); Step = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (Out_Strobe === 1'b1) seen = 1; else @(negedge Clk);
    end
    check("out_strobe_seen", 32'(seen), 32'd1);
    cnt = 0; busy_all = 1;
    while (Out_Strobe === 1'b1 && cnt < 100) begin
      cnt++;
      busy_all &= (Busy === 1'b1);
      @(negedge Clk);
    end
    check("out_strobe_len", 32'(cnt), 32'(out_delay + 1));
    check("out_busy", 32'(busy_all), 32'd1);
    wait_halted("io_halt");
    check("io_retired", 32'(Retired), 32'd4);
    check("io_sb_empty", 32'(exp_q.size()), 32'd0);

    // Run falls while a slow data op is outstanding
    apply_reset();
    prog = {INSN_INC, INSN_INC}; pc = 0;
    data_delay = 12;
    exp_q.push_back(EV_D_INC);
    ip_start = ip_cnt;
    Run = 1'b1;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge Clk);
      seen = (Data_Request === 1'b1);
    end
    check("runfall_req_seen", 32'(seen), 32'd1);
    Run = 1'b0;
    repeat (40) @(negedge Clk);
    check("runfall_retired", 32'(Retired), 32'd1);
    check("runfall_idle", 32'(Busy), 32'd0);
    check("runfall_one_fetch", 32'(ip_cnt - ip_start), 32'd1);
    check("runfall_not_halted", 32'(Halted), 32'd0);
    check("runfall_sb_empty", 32'(exp_q.size()), 32'd0);

    // reset during an output handshake; late ack lands while idle
    prog = {INSN_OUT}; pc = 0;
    out_delay = 20;
    exp_q.push_back(EV_OUT);
    Run = 1'b1;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge Clk);
      seen = (Out_Strobe === 1'b1);
    end
    check("rstmid_strobe_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b0; Run = 1'b0;
    @(negedge Clk);
    check("rstmid_strobe_drop", 32'(Out_Strobe), 32'd0);
    Rst_n = 1'b1;
    repeat (30) @(negedge Clk);
    check("rstmid_retired", 32'(Retired), 32'd0);
    check("rstmid_idle", 32'({Busy, Out_Strobe}), 32'd0);
    check("rstmid_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
